// File: rtl/mac_acc_ctrl.sv
// mac_acc_ctrl: sequences one accumulator run per command.
// The run goes IDLE -> CLEAR (one init-load pulse) -> RUN (one enable per
// accepted beat) -> DRAIN (fixed pipeline flush) -> HOLD (result offered).
// Optional feature macro: MAC_ACC_CTRL_TIMEOUT_EN adds an idle-input
// watchdog that aborts RUN after TIMEOUT consecutive idle cycles and flags err.
module mac_acc_ctrl #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int CNT_WIDTH      = 16,
    parameter int DRAIN_CYCLES   = 1,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CNT_WIDTH-1:0]      cmd_len,
    input  logic [MAC_CONF_WIDTH-1:0] cmd_cfg,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      acc_rst,
    output logic                      acc_en,
    output logic [MAC_CONF_WIDTH-1:0] acc_cfg,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0]           DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CNT_WIDTH-1:0]      r_count;
    logic [MAC_CONF_WIDTH-1:0] r_cfg;
    logic [3:0]                r_drain_cnt;
    logic                      w_cmd_fire;
    logic                      w_last_beat;
    logic                      w_drain_done;
    logic                      w_timeout;

    assign w_cmd_fire   = cmd_valid & cmd_ready;
    assign w_last_beat  = acc_en && (r_count == CNT_ONE);
    assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

`ifdef MAC_ACC_CTRL_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    // Timeout fires on the TIMEOUT-th consecutive idle RUN cycle.
    assign w_timeout = (r_state == S_RUN) && !in_valid && (r_wd_cnt == WD_LAST);
    assign err       = r_err;

    // Watchdog: counts consecutive idle RUN cycles, restarts on any beat or outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_RUN || acc_en) begin
            r_wd_cnt <= '0;
        end else if (!in_valid) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Abort flag: set on timeout, cleared as the result is handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (r_state == S_HOLD && res_ready) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused_timeout;

    // No watchdog: RUN waits for every beat, a run can never be aborted.
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake/strobe outputs.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        acc_rst      = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_rst      = 1'b1;
                w_state_next = (r_count != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (w_timeout || (in_valid && r_count == CNT_ONE)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign acc_en  = in_valid & in_ready;
    assign busy    = (r_state != S_IDLE);
    assign acc_cfg = r_cfg;

    // Command latch and remaining-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_cfg   <= '0;
        end else if (w_cmd_fire) begin
            r_count <= cmd_len;
            r_cfg   <= cmd_cfg;
        end else if (acc_en) begin
            r_count <= w_last_beat ? '0 : r_count - 1'b1;
        end
    end

    // Drain timer: runs only while in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

endmodule
